// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle: FIFO controller read port plus the outgoing valid/ready stream.
interface fifo_rd_stream_if #(
  parameter int unsigned c_DATA_WIDTH = 16
);
  logic                    r_en;
  logic                    rempty;
  logic [c_DATA_WIDTH-1:0] rdata;
  logic                    m_valid;
  logic [c_DATA_WIDTH-1:0] m_data;
  logic                    m_ready;

  modport master (
    output r_en,
    input  rempty,
    input  rdata,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  r_en,
    output rempty,
    output rdata,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: turns the FIFO r_en/rempty port into a first-word-fall-through
// stream, hiding RAM read latency behind a credit-controlled prefetch buffer.
module fifo_rd_stream #(
  parameter int unsigned c_DATA_WIDTH = 16,
  parameter int unsigned c_RD_LATENCY = 1,
  parameter int unsigned c_BUF_AW     = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  fifo_rd_stream_if.master    bus,
  input  logic                cnt_clr,
  output logic [c_BUF_AW:0]   buf_level,
  output logic [31:0]         rd_cnt
);

  localparam logic [c_BUF_AW+1:0] c_DEPTH = (c_BUF_AW+2)'(2**c_BUF_AW);

  logic                    run;
  logic [c_RD_LATENCY-1:0] inflight;
  logic [c_BUF_AW:0]       inflight_cnt;
  logic [c_BUF_AW+1:0]     credit;
  logic [c_BUF_AW:0]       level_q;
  logic [c_BUF_AW-1:0]     wr_ptr;
  logic [c_BUF_AW-1:0]     rd_ptr;
  logic [c_DATA_WIDTH-1:0] mem [2**c_BUF_AW];
  logic [31:0]             cnt_q;
  logic                    pop;
  logic                    wr;
  logic                    deq;

  always_comb begin
    inflight_cnt = '0;
    for (int unsigned k = 0; k < c_RD_LATENCY; k++) begin
      inflight_cnt = inflight_cnt + {{c_BUF_AW{1'b0}}, inflight[k]};
    end
  end

  // Credit counts buffered plus in-flight words; a same-cycle dequeue is not credited.
  assign credit = {1'b0, level_q} + {1'b0, inflight_cnt};
  assign pop    = run & ~bus.rempty & (credit < c_DEPTH);
  assign wr     = inflight[c_RD_LATENCY-1];
  assign deq    = (level_q != '0) & bus.m_ready;

  assign bus.r_en    = pop;
  assign bus.m_valid = (level_q != '0);
  assign bus.m_data  = mem[rd_ptr];
  assign buf_level   = level_q;
  assign rd_cnt      = cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run      <= 1'b0;
      inflight <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= (inflight << 1) | c_RD_LATENCY'(pop);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wr_ptr <= '0;
      for (int unsigned i = 0; i < 2**c_BUF_AW; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[wr_ptr] <= bus.rdata;
      wr_ptr      <= wr_ptr + c_BUF_AW'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (deq) begin
        rd_ptr <= rd_ptr + c_BUF_AW'(1);
      end
      case ({wr, deq})
        2'b10:   level_q <= level_q + (c_BUF_AW+1)'(1);
        2'b01:   level_q <= level_q - (c_BUF_AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (deq) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule
